idelay_tap_ctrl: RTL and testbench

Sequencer that owns the tap-load ports of `N_LANES` `DATA_IDELAY` instances on one ADC, sharing a single request port among them. It loads a default tap into every lane after reset and serialises software tap writes and reads. It respects the `DATA_IDELAY` 2-stage input and 2-stage output register pipelines. It sits between the register/bitslip-training logic and the per-lane `DATA_IDELAY` instances, in the `clk_div` domain.

---
 rtl/idelay_ctrl_pkg.sv | 17 +
 rtl/idelay_tap_bank.sv | 34 +++
 rtl/idelay_tap_ctrl.sv | 134 +++++++++++++
 tb/tb_idelay_tap_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/idelay_ctrl_pkg.sv
// idelay_ctrl_pkg: shared constants and FSM state type for the IDELAY tap-load sequencer.
// TAP_W is the CNTVALUE width; SETTLE_MIN is the shortest safe gap after a load pulse,
// covering the 2-stage input pipeline, the load cycle and the 2-stage output pipeline.
package idelay_ctrl_pkg;
    localparam int TAP_W           = 9;
    localparam int IDELAY_PIPE_IN  = 2;
    localparam int IDELAY_PIPE_OUT = 2;
    localparam int SETTLE_MIN      = IDELAY_PIPE_IN + 1 + IDELAY_PIPE_OUT;
    typedef enum logic [2:0] {
        INIT_LOAD,
        INIT_WAIT,
        IDLE,
        LOAD,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/idelay_tap_bank.sv
// idelay_tap_bank: per-lane held tap registers and one-hot load-pulse generator.
// Ports: clk_div/rst_n (async active-low), wr_en/wr_idx/wr_tap write strobe,
// lane_load one-cycle pulse to the addressed lane, lane_tap packed held taps (9 bits per lane).
module idelay_tap_bank
    import idelay_ctrl_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int LIDX    = 3
) (
    input  logic                       clk_div,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [LIDX-1:0]            wr_idx,
    input  logic [TAP_W-1:0]           wr_tap,
    output logic [N_LANES-1:0]         lane_load,
    output logic [N_LANES*TAP_W-1:0]   lane_tap
);
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic             hit, ld;
        logic [TAP_W-1:0] tap;
        assign hit = wr_en && wr_idx == LIDX'(i);
        assign lane_load[i] = ld;
        assign lane_tap[i*TAP_W +: TAP_W] = tap;
        always_ff @(posedge clk_div or negedge rst_n) begin
            if (!rst_n) begin
                ld  <= 1'b0;
                tap <= '0;
            end else begin
                ld <= hit;
                if (hit) tap <= wr_tap;
            end
        end
    end
endmodule

// File: rtl/idelay_tap_ctrl.sv
// idelay_tap_ctrl: sequencer owning the tap-load ports of N_LANES DATA_IDELAY lanes.
// Ports: clk_div/rst_n (async active-low); req_* single request port (valid/ready,
// wr, lane, tap); rsp_* one-cycle response strobe with lane/tap/err; init_done after the
// post-reset sweep; lane_load/lane_tap drive the lanes; lane_tap_rb is their CNTVALUEOUT.
// Build option IDELAY_TAP_VERIFY_EN: write responses return the lane readback, flag a
// mismatch in rsp_err and count mismatches (init sweep included) in verify_err_cnt.
module idelay_tap_ctrl
    import idelay_ctrl_pkg::*;
#(
    parameter int N_LANES    = 8,
    parameter int INIT_TAP   = 0,
    parameter int SETTLE_CYC = 6
) (
    input  logic                       clk_div,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [7:0]                 req_lane,
    input  logic [TAP_W-1:0]           req_tap,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_lane,
    output logic [TAP_W-1:0]           rsp_tap,
    output logic                       rsp_err,
    output logic                       init_done,
    output logic [N_LANES-1:0]         lane_load,
    output logic [N_LANES*TAP_W-1:0]   lane_tap,
    input  logic [N_LANES*TAP_W-1:0]   lane_tap_rb
`ifdef IDELAY_TAP_VERIFY_EN
    ,
    output logic [15:0]                verify_err_cnt
`endif
);
    localparam int LIDX = N_LANES > 1 ? $clog2(N_LANES) : 1;
    localparam int CW   = $clog2(SETTLE_CYC + 1);
    localparam logic [TAP_W-1:0] INIT_V = TAP_W'(INIT_TAP);
`ifdef IDELAY_TAP_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    if (SETTLE_CYC < SETTLE_MIN) begin : g_settle_chk
        $error("SETTLE_CYC is shorter than the DATA_IDELAY pipeline");
    end
    logic [TAP_W-1:0] rb [N_LANES];
    for (genvar i = 0; i < N_LANES; i++) begin : g_rb
        assign rb[i] = lane_tap_rb[i*TAP_W +: TAP_W];
    end
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [LIDX-1:0]  ptr;
    logic [7:0]       lane_q;
    logic [TAP_W-1:0] tap_q, rb_q;
    logic             wr_q, ok_q, req_ok, settled;
    assign req_ready = state == IDLE;
    assign req_ok    = int'(req_lane) < N_LANES;
    assign ok_q      = int'(lane_q) < N_LANES;
    assign settled   = cnt == CW'(1);
    assign rb_q      = rb[lane_q[LIDX-1:0]];
    // A write's settle count starts at accept, so LOAD is the first of its SETTLE_CYC cycles.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT_LOAD;
            cnt       <= '0;
            ptr       <= '0;
            lane_q    <= '0;
            tap_q     <= '0;
            wr_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_lane  <= '0;
            rsp_tap   <= '0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                INIT_LOAD: begin
                    state <= INIT_WAIT;
                    cnt   <= CW'(SETTLE_CYC);
                end
                INIT_WAIT: begin
                    if (settled) begin
                        ptr       <= ptr + 1'b1;
                        state     <= ptr == LIDX'(N_LANES - 1) ? IDLE : INIT_LOAD;
                        init_done <= ptr == LIDX'(N_LANES - 1);
                    end else cnt <= cnt - 1'b1;
                end
                IDLE: begin
                    if (req_valid) begin
                        lane_q <= req_lane;
                        tap_q  <= req_tap;
                        wr_q   <= req_wr;
                        cnt    <= CW'(SETTLE_CYC);
                        state  <= req_wr && req_ok ? LOAD : RESP;
                    end
                end
                LOAD: begin
                    state <= WAIT;
                    cnt   <= cnt - 1'b1;
                end
                WAIT: begin
                    if (settled) state <= RESP;
                    else cnt <= cnt - 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_lane  <= lane_q;
                    rsp_tap   <= !ok_q ? '0 : (wr_q && !VERIFY) ? tap_q : rb_q;
                    rsp_err   <= !ok_q || (VERIFY && wr_q && rb_q != tap_q);
                end
                default: state <= INIT_LOAD;
            endcase
        end
    end
    idelay_tap_bank #(.N_LANES(N_LANES), .LIDX(LIDX)) u_bank (
        .clk_div   (clk_div),
        .rst_n     (rst_n),
        .wr_en     (state == INIT_LOAD || state == LOAD),
        .wr_idx    (state == INIT_LOAD ? ptr : lane_q[LIDX-1:0]),
        .wr_tap    (state == INIT_LOAD ? INIT_V : tap_q),
        .lane_load (lane_load),
        .lane_tap  (lane_tap)
    );
`ifdef IDELAY_TAP_VERIFY_EN
    logic mism;
    assign mism = (state == INIT_WAIT && settled && rb[ptr] != INIT_V) ||
                  (state == RESP && wr_q && ok_q && rb_q != tap_q);
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) verify_err_cnt <= '0;
        else if (mism && verify_err_cnt != 16'hFFFF) verify_err_cnt <= verify_err_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// tb_idelay_tap_ctrl: directed plus randomized bench for idelay_tap_ctrl against a lane-tap model.
module tb_idelay_tap_ctrl;
    localparam int N  = 8;
    localparam int S  = 6;
    localparam int IT = 37;
    localparam int TW = 9;
    localparam int PW = N * TW;

    logic          clk_div = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, req_wr = 1'b0;
    logic [7:0]    req_lane = '0;
    logic [TW-1:0] req_tap = '0;
    logic          req_ready, rsp_valid, rsp_err, init_done;
    logic [7:0]    rsp_lane;
    logic [TW-1:0] rsp_tap;
    logic [N-1:0]  lane_load;
    logic [PW-1:0] lane_tap, lane_tap_rb;
`ifdef IDELAY_TAP_VERIFY_EN
    logic [15:0]   verify_err_cnt;
`endif

    int vectors = 0, miscompares = 0;
    int model_tap [N];
    int rb [N];

    always #5 clk_div = ~clk_div;

    for (genvar g = 0; g < N; g++) begin : g_rb
        assign lane_tap_rb[g*TW +: TW] = TW'(rb[g]);
    end

    idelay_tap_ctrl #(.N_LANES(N), .INIT_TAP(IT), .SETTLE_CYC(S)) dut (
        .clk_div     (clk_div),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_lane    (req_lane),
        .req_tap     (req_tap),
        .rsp_valid   (rsp_valid),
        .rsp_lane    (rsp_lane),
        .rsp_tap     (rsp_tap),
        .rsp_err     (rsp_err),
        .init_done   (init_done),
        .lane_load   (lane_load),
        .lane_tap    (lane_tap),
        .lane_tap_rb (lane_tap_rb)
`ifdef IDELAY_TAP_VERIFY_EN
        ,
        .verify_err_cnt (verify_err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] packed_model();
        logic [PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*TW +: TW] = TW'(model_tap[i]);
        return r;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 200 && req_ready !== 1'b1; i++) @(negedge clk_div);
        chk("ready_timeout", PW'(req_ready), PW'(1'b1));
    endtask

    // Releases reset and follows the sweep: lane i is loaded after edge i*(S+1)+1.
    // With hold set, a read of lane 2 waits at the port and is taken the cycle IDLE begins.
    task automatic init_sweep(input bit hold);
        logic [N-1:0]  el;
        logic [PW-1:0] et;
        int            done_c;
        done_c = N * (S + 1);
        for (int i = 0; i < N; i++) begin
            model_tap[i] = IT;
            rb[i]        = IT;
        end
        req_valid = hold;
        req_wr    = 1'b0;
        req_lane  = 8'd2;
        @(negedge clk_div);
        rst_n = 1'b1;
        for (int c = 1; c <= done_c + 4; c++) begin
            @(negedge clk_div);
            el = ((c - 1) % (S + 1) == 0 && (c - 1) / (S + 1) < N) ? N'(1) << ((c - 1) / (S + 1)) : '0;
            for (int i = 0; i < N; i++) et[i*TW +: TW] = (c >= i * (S + 1) + 1) ? TW'(IT) : '0;
            chk("init_load", PW'(lane_load), PW'(el));
            chk("init_tap", lane_tap, et);
            chk("init_done", PW'(init_done), PW'(c >= done_c));
            chk("init_ready", PW'(req_ready), PW'(c >= done_c && !(hold && c == done_c + 1)));
            chk("init_rsp", PW'(rsp_valid), PW'(hold && c == done_c + 2));
            if (hold && c == done_c + 2) chk("init_rd_tap", PW'(rsp_tap), PW'(IT));
            if (c == done_c + 1) req_valid = 1'b0;
        end
    endtask

    // rbw >= 0 forces the lane readback after a write instead of an ideal mirror.
    task automatic xact(input bit wr, input int lane, input int tap, input int rbv, input int rbw);
        bit            ok;
        int            lat, etap;
        bit            eerr;
        logic [N-1:0]  el;
        ok   = lane < N;
        lat  = (wr && ok) ? S + 1 : 1;
        etap = !ok ? 0 : !wr ? rbv : tap;
        eerr = !ok;
`ifdef IDELAY_TAP_VERIFY_EN
        if (wr && ok && rbw >= 0) begin
            etap = rbw;
            eerr = rbw != tap;
        end
`endif
        wait_ready();
        if (ok && !wr) rb[lane] = rbv;
        req_valid = 1'b1;
        req_wr    = wr;
        req_lane  = 8'(lane);
        req_tap   = TW'(tap);
        @(posedge clk_div);
        #1 req_valid = 1'b0;
        if (wr && ok) begin
            model_tap[lane] = tap;
            rb[lane]        = rbw >= 0 ? rbw : tap;
        end
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk_div);
            el = (wr && ok && k == 1) ? N'(1) << lane : '0;
            chk("x_load", PW'(lane_load), PW'(el));
            chk("x_rsp_valid", PW'(rsp_valid), PW'(k == lat));
            chk("x_ready", PW'(req_ready), PW'(k >= lat));
            if (k == lat) begin
                chk("x_rsp_lane", PW'(rsp_lane), PW'(lane));
                chk("x_rsp_tap", PW'(rsp_tap), PW'(etap));
                chk("x_rsp_err", PW'(rsp_err), PW'(eerr));
                chk("x_lane_tap", lane_tap, packed_model());
            end
        end
    endtask

    // Write lane 1, then keep req_valid high with a read of lane 6 through the write's wait.
    task automatic held_during_wait();
        int tap, rbv;
        tap = int'($urandom_range(0, 511));
        rbv = int'($urandom_range(0, 511));
        wait_ready();
        rb[6]     = rbv;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_lane  = 8'd1;
        req_tap   = TW'(tap);
        @(posedge clk_div);
        #1;
        req_wr       = 1'b0;
        req_lane     = 8'd6;
        model_tap[1] = tap;
        rb[1]        = tap;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk_div);
            chk("h_load", PW'(lane_load), PW'(k == 1 ? N'(2) : N'(0)));
            chk("h_ready", PW'(req_ready), PW'(k == S + 1 || k >= S + 3));
            chk("h_rsp_valid", PW'(rsp_valid), PW'(k == S + 1 || k == S + 3));
            if (k == S + 1) chk("h_wr_tap", PW'(rsp_tap), PW'(tap));
            if (k == S + 3) begin
                chk("h_rd_lane", PW'(rsp_lane), PW'(6));
                chk("h_rd_tap", PW'(rsp_tap), PW'(rbv));
            end
            if (k == S + 2) req_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            model_tap[i] = 0;
            rb[i]        = IT;
        end
        @(negedge clk_div);
        chk("rst_load", PW'(lane_load), PW'(0));
        chk("rst_tap", lane_tap, PW'(0));
        chk("rst_rsp_valid", PW'(rsp_valid), PW'(0));
        chk("rst_ready", PW'(req_ready), PW'(0));
        chk("rst_init_done", PW'(init_done), PW'(0));
        chk("rst_rsp_fields", PW'({rsp_lane, rsp_tap, rsp_err}), PW'(0));

        init_sweep(1'b0);
        xact(1'b1, 3, 300, 0, -1);
        xact(1'b0, 5, 0, 123, -1);
        xact(1'b1, 9, 55, 0, -1);
        xact(1'b0, 200, 0, 0, -1);
        xact(1'b1, 0, 511, 0, -1);
        xact(1'b1, N - 1, 0, 0, -1);
        xact(1'b0, N - 1, 0, 511, -1);
        held_during_wait();
        repeat (25) begin
            xact(1'($urandom_range(0, 1)), int'($urandom_range(0, N + 3)),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), -1);
        end
`ifdef IDELAY_TAP_VERIFY_EN
        chk("verr_before", PW'(verify_err_cnt), PW'(0));
        xact(1'b1, 3, 300, 0, 299);
        chk("verr_after", PW'(verify_err_cnt), PW'(1));
`endif

        wait_ready();
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_lane  = 8'd4;
        req_tap   = TW'(200);
        @(posedge clk_div);
        #1 req_valid = 1'b0;
        @(negedge clk_div);
        @(negedge clk_div);
        chk("mid_load_pre", PW'(lane_load), PW'(N'(1) << 4));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_load", PW'(lane_load), PW'(0));
        chk("mid_rsp_valid", PW'(rsp_valid), PW'(0));
        chk("mid_tap", lane_tap, PW'(0));
        chk("mid_ready", PW'(req_ready), PW'(0));
        chk("mid_init_done", PW'(init_done), PW'(0));
        init_sweep(1'b1);
        xact(1'b0, 4, 0, 77, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
